// File: rtl/mux_select_arbiter_pkg.sv
// Shared definitions for the 5-requester mux select arbiter.
//   N_REQ      number of requesters sharing the 5:1 datapath
//   SEL_W      width of the mux select
//   state_e    arbiter state (idle / grant held)
//   wrap_inc   index + 1, wrapping mod N_REQ
//   onehot     select index to one-hot grant vector
package mux_select_arbiter_pkg;

    localparam int N_REQ = 5;
    localparam int SEL_W = 3;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_e;

    function automatic logic [SEL_W-1:0] wrap_inc(input logic [SEL_W-1:0] i);
        return (i == SEL_W'(N_REQ - 1)) ? '0 : i + 1'b1;
    endfunction

    function automatic logic [N_REQ-1:0] onehot(input logic [SEL_W-1:0] i);
        return N_REQ'(1) << i;
    endfunction

endpackage

// File: rtl/mux_select_arbiter_rr_pick5.sv
// Combinational round-robin picker.
//   req   [4:0]  request vector
//   start [2:0]  index scanned first (0..4)
//   mask  [4:0]  requesters excluded from the scan
//   found        some unmasked requester is set
//   idx   [2:0]  first unmasked requester found scanning start, start+1, ... mod 5
module rr_pick5
    import mux_select_arbiter_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [SEL_W-1:0] start,
    input  logic [N_REQ-1:0] mask,
    output logic             found,
    output logic [SEL_W-1:0] idx
);

    logic [N_REQ-1:0] cand;
    logic [SEL_W:0]   pos;

    assign cand = req & ~mask;

    // Scan from the far end back toward start so the nearest hit wins.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        pos   = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            pos = {1'b0, start} + (SEL_W+1)'(k);
            if (pos >= (SEL_W+1)'(N_REQ))
                pos = pos - (SEL_W+1)'(N_REQ);
            if (cand[pos[SEL_W-1:0]]) begin
                found = 1'b1;
                idx   = pos[SEL_W-1:0];
            end
        end
    end

endmodule

// File: rtl/mux_select_arbiter.sv
// Round-robin arbiter sharing one 5:1 mux among five requesters, with each
// tenure bounded by a dwell limit while other requesters wait.
//   clk    rising-edge clock
//   reset  asynchronous active-high reset
//   req    [4:0] request vector, held for the whole tenure
//   grant  [4:0] registered one-hot grant, zero when idle
//   sel    [2:0] registered mux select (owner index), zero when idle
//   busy   registered, equal to |grant
module mux_select_arbiter
    import mux_select_arbiter_pkg::*;
#(
    parameter int MAX_DWELL = 8,
    parameter int DWELL_W   = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] grant,
    output logic [SEL_W-1:0] sel,
    output logic             busy
);

    localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(MAX_DWELL - 1);

    state_e             state_q, state_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [N_REQ-1:0]   grant_q, grant_d;
    logic               busy_q, busy_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic [SEL_W-1:0]   ptr_q, ptr_d;

    logic [SEL_W-1:0]   pick_start;
    logic [N_REQ-1:0]   pick_mask;
    logic               pick_found;
    logic [SEL_W-1:0]   pick_idx;
    logic               owner_req;
    logic               handoff;

    // Idle scans from the priority pointer; a tenure scans from the slot after
    // the owner and excludes the owner, so a waiting requester always wins.
    assign pick_start = (state_q == ST_IDLE) ? ptr_q : wrap_inc(sel_q);
    assign pick_mask  = (state_q == ST_IDLE) ? '0 : onehot(sel_q);
    assign owner_req  = req[sel_q];
    assign handoff    = !owner_req || (dwell_q == DWELL_LAST);

    rr_pick5 u_pick (
        .req   (req),
        .start (pick_start),
        .mask  (pick_mask),
        .found (pick_found),
        .idx   (pick_idx)
    );

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        busy_d  = busy_q;
        dwell_d = dwell_q;
        ptr_d   = ptr_q;
        unique case (state_q)
            ST_IDLE: begin
                if (pick_found) begin
                    state_d = ST_GRANT;
                    sel_d   = pick_idx;
                    busy_d  = 1'b1;
                    dwell_d = '0;
                    ptr_d   = wrap_inc(pick_idx);
                end
            end
            ST_GRANT: begin
                if (handoff && pick_found) begin
                    sel_d   = pick_idx;
                    dwell_d = '0;
                    ptr_d   = wrap_inc(pick_idx);
                end else if (handoff && owner_req) begin
                    // Nobody else waiting: the owner simply starts a new tenure.
                    dwell_d = '0;
                end else if (!owner_req) begin
                    state_d = ST_IDLE;
                    sel_d   = '0;
                    busy_d  = 1'b0;
                    dwell_d = '0;
                end else if (dwell_q != DWELL_LAST) begin
                    dwell_d = dwell_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                sel_d   = '0;
                busy_d  = 1'b0;
                dwell_d = '0;
            end
        endcase
        grant_d = busy_d ? onehot(sel_d) : '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            sel_q   <= '0;
            grant_q <= '0;
            busy_q  <= 1'b0;
            dwell_q <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            grant_q <= grant_d;
            busy_q  <= busy_d;
            dwell_q <= dwell_d;
            ptr_q   <= ptr_d;
        end
    end

    assign grant = grant_q;
    assign sel   = sel_q;
    assign busy  = busy_q;

endmodule

// File: tb/tb_mux_select_arbiter.sv
module tb_mux_select_arbiter;

    logic       clk;
    logic       reset;
    logic [4:0] req8, req2;
    logic [4:0] grant8, grant2;
    logic [2:0] sel8, sel2;
    logic       busy8, busy2;

    int total = 0;
    int bad   = 0;

    typedef struct {
        bit      which;  // 0: MAX_DWELL=8 instance, 1: MAX_DWELL=2 instance
        int      esel;
        bit      ebusy;
    } exp_t;

    exp_t sb[$];

    mux_select_arbiter #(.MAX_DWELL(8), .DWELL_W(4)) dut8 (
        .clk(clk), .reset(reset), .req(req8),
        .grant(grant8), .sel(sel8), .busy(busy8)
    );

    mux_select_arbiter #(.MAX_DWELL(2), .DWELL_W(2)) dut2 (
        .clk(clk), .reset(reset), .req(req2),
        .grant(grant2), .sel(sel2), .busy(busy2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_g8"}, 32'(grant8), 32'd0);
        chk({tag, "_s8"}, 32'(sel8), 32'd0);
        chk({tag, "_b8"}, 32'(busy8), 32'd0);
        chk({tag, "_g2"}, 32'(grant2), 32'd0);
        chk({tag, "_s2"}, 32'(sel2), 32'd0);
        chk({tag, "_b2"}, 32'(busy2), 32'd0);
    endtask

    // Drive one cycle of stimulus at a negedge, push what the next posedge
    // must produce, then compare at the following negedge.
    task automatic step(input bit which, input logic [4:0] r, input int esel, input bit ebusy,
                        input string tag);
        exp_t e;
        logic [4:0] g;
        logic [2:0] s;
        logic       b;
        logic [4:0] eg;
        if (which) req2 = r; else req8 = r;
        e.which = which; e.esel = esel; e.ebusy = ebusy;
        sb.push_back(e);
        @(negedge clk);
        e = sb.pop_front();
        g = e.which ? grant2 : grant8;
        s = e.which ? sel2 : sel8;
        b = e.which ? busy2 : busy8;
        eg = e.ebusy ? (5'd1 << e.esel) : 5'd0;
        chk({tag, "_grant"}, 32'(g), 32'(eg));
        chk({tag, "_sel"}, 32'(s), 32'(e.esel));
        chk({tag, "_busy"}, 32'(b), 32'(e.ebusy));
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk_idle(tag);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        req8  = 5'b0;
        req2  = 5'b0;
        repeat (2) @(negedge clk);

        // Reset held with every requester active: nothing granted.
        req8 = 5'b11111;
        @(negedge clk);
        chk_idle("rst_hold");
        reset = 1'b0;
        step(0, 5'b11111, 0, 1, "rst_rel");
        // Owner 0 keeps the mux for 8 cycles total, then rotates to 1.
        for (int i = 0; i < 7; i++) step(0, 5'b11111, 0, 1, "dwell8_hold");
        step(0, 5'b11111, 1, 1, "dwell8_rot");

        // Single requester then release.
        do_reset("rst2");
        step(0, 5'b00100, 2, 1, "single_a");
        step(0, 5'b00100, 2, 1, "single_b");
        step(0, 5'b00100, 2, 1, "single_c");
        step(0, 5'b00000, 0, 0, "single_drop");
        step(0, 5'b00000, 0, 0, "single_idle");

        // Early release by owner 3 wraps past 4 to requester 0.
        step(0, 5'b01000, 3, 1, "early_own3");
        step(0, 5'b01001, 3, 1, "early_d1");
        step(0, 5'b00001, 0, 1, "early_wrap");
        step(0, 5'b00000, 0, 0, "early_idle");

        // Sole owner across several dwell limits keeps the grant.
        for (int i = 0; i < 20; i++) step(0, 5'b00010, 1, 1, "sole_hold");
        step(0, 5'b00000, 0, 0, "sole_drop");

        // Async reset between edges while sel=3.
        step(0, 5'b01000, 3, 1, "async_own3");
        #2;
        reset = 1'b1;
        #1;
        chk("async_grant", 32'(grant8), 32'd0);
        chk("async_sel", 32'(sel8), 32'd0);
        chk("async_busy", 32'(busy8), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("async_rel_grant", 32'(grant8), 32'd0);
        @(negedge clk);
        chk("async_rel_busy", 32'(busy8), 32'd1);
        chk("async_rel_sel", 32'(sel8), 32'd3);
        req8 = 5'b0;

        // Full rotation with MAX_DWELL=2: two cycles per owner, no gaps.
        do_reset("rst3");
        for (int i = 0; i < 12; i++) step(1, 5'b11111, (i / 2) % 5, 1, "rot2");
        step(1, 5'b00000, 0, 0, "rot2_idle");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Runaway guard.
    initial begin
        #100000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end

endmodule
